// File: rtl/serial_sub.sv
// Bit-serial subtractor: {b_out, d} = a - b - b_in, one bit per clock, LSB first.
// Operands are captured on the accepting edge; the result registers change only on entry to DONE.
module serial_sub #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             b_out
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_br;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_d;
    logic             r_bout;
    logic             r_busy;
    logic             r_done;

    logic             w_ai;
    logic             w_bi;
    logic             w_diff;
    logic             w_br_next;
    logic             w_last;
    logic [WIDTH-1:0] w_res_next;

    assign w_ai       = r_a[0];
    assign w_bi       = r_b[0];
    assign w_diff     = w_ai ^ w_bi ^ r_br;
    assign w_br_next  = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_br);
    assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
    // Difference bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    assign w_res_next = {w_diff, r_res[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_d     <= '0;
            r_bout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_br    <= b_in;
                        r_res   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_br  <= w_br_next;
                    r_res <= w_res_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_d     <= w_res_next;
                        r_bout  <= w_br_next;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign d     = r_d;
    assign b_out = r_bout;

endmodule
